parse_act_sched: RTL and testbench

- Sequencer in front of a single sub_parser lane.
- Accepts one packet header plus its parse-action list, and issues the enabled actions to the sub_parser one per cycle.
- Collects the returned 2B/4B/6B values into a packed PHV container image, then presents that PHV downstream on a valid/ready handshake.
- Sits between the parse-table lookup and the PHV deparser/stage-0 input.

---
 rtl/parse_act_sched.sv | 191 +++++++++++++++++++
 tb/tb_parse_act_sched.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parse_act_sched.sv
// -----------------------------------------------------------------------------
// parse_act_sched
//
// Sequencer in front of a single sub_parser lane. Accepts one packet header
// plus its parse-action list, issues every enabled action (bit0 = 1) to the
// sub_parser at a fixed cadence of one action index per cycle, collects the
// returned 2B/4B/6B values into a packed PHV container image, and presents
// that PHV downstream on a valid/ready handshake.
//
// Timing, with the input handshake sampled in cycle T:
//   action k visible on parse_act        : cycle T+1+k (only when enabled)
//   phv_valid first asserted              : cycle T+NUM_ACTS+2
//
// PHV layout (j = container index 0..CONT_NUM-1):
//   2B : phv_out[16*j +: 16]
//   4B : phv_out[16*CONT_NUM + 32*j +: 32]
//   6B : phv_out[48*CONT_NUM + 48*j +: 48]
//
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   s_valid/s_ready       header+actions handshake from the parse-table lookup
//   s_pkts_hdr            packet header
//   s_parse_acts          action k at [k*PARSE_ACT_LEN +: PARSE_ACT_LEN]
//   pkts_hdr              latched header towards the sub_parser
//   parse_act_valid       action issue strobe
//   parse_act             action towards the sub_parser
//   val_in_valid          sub_parser result valid
//   val_in                extracted value (up to 48 bits)
//   val_in_type           01=2B, 10=4B, 11=6B, 00=none
//   val_in_seq            container index; only [2:0] is used
//   phv_valid/phv_ready   PHV handshake towards the deparser / stage 0
//   phv_out               packed container image
//
// Optional build macro PARSE_ERR_CNT_EN adds:
//   err_cnt               saturating 16-bit count of enabled actions with type
//                         field [8:7]=00 plus results returned with type 00
// -----------------------------------------------------------------------------
module parse_act_sched #(
  parameter int PKTS_HDR_LEN  = 4096,
  parameter int PARSE_ACT_LEN = 24,
  parameter int NUM_ACTS      = 10,
  parameter int CONT_NUM      = 8,
  parameter int PHV_LEN       = CONT_NUM * (16 + 32 + 48)
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [PKTS_HDR_LEN-1:0]           s_pkts_hdr,
  input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0] s_parse_acts,
  output logic [PKTS_HDR_LEN-1:0]           pkts_hdr,
  output logic                              parse_act_valid,
  output logic [PARSE_ACT_LEN-1:0]          parse_act,
  input  logic                              val_in_valid,
  input  logic [47:0]                       val_in,
  input  logic [1:0]                        val_in_type,
  input  logic [5:0]                        val_in_seq,
  output logic                              phv_valid,
  input  logic                              phv_ready,
  output logic [PHV_LEN-1:0]                phv_out
`ifdef PARSE_ERR_CNT_EN
  ,
  output logic [15:0]                       err_cnt
`endif
);

  localparam int               IDX_W   = $clog2(NUM_ACTS + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_ACTS);
  localparam int               BASE_4B = CONT_NUM * 16;
  localparam int               BASE_6B = CONT_NUM * 48;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;        // next action index to present
  logic [PARSE_ACT_LEN-1:0] acts_q [NUM_ACTS];

  logic                     accept;
  logic                     issue_now;
  logic [PARSE_ACT_LEN-1:0] issue_act;

  assign s_ready = (state == IDLE);
  assign accept  = s_valid && s_ready;

  // Action to be presented after the coming edge. Action 0 comes straight
  // from the input bus so that it is already visible in cycle T+1.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    issue_now = 1'b0;
    issue_act = '0;
    if (accept) begin
      issue_now = 1'b1;
      issue_act = s_parse_acts[PARSE_ACT_LEN-1:0];
    end else if (state == ISSUE && idx != IDX_END) begin
      issue_now = 1'b1;
      issue_act = acts_q[idx];
    end
  end

  // Sequencer FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      idx             <= '0;
      pkts_hdr        <= '0;
      parse_act_valid <= 1'b0;
      parse_act       <= '0;
      phv_valid       <= 1'b0;
      // NOTE: the action store is small and cleared on reset like any other
      // register; a large RAM would instead be left unreset.
      for (int k = 0; k < NUM_ACTS; k++) acts_q[k] <= '0;
    end else begin
      // Disabled slots drop the strobe but keep the last issued action.
      parse_act_valid <= issue_now && issue_act[0];
      if (issue_now && issue_act[0]) parse_act <= issue_act;

      unique case (state)
        IDLE: begin
          if (accept) begin
            pkts_hdr <= s_pkts_hdr;
            for (int k = 0; k < NUM_ACTS; k++)
              acts_q[k] <= s_parse_acts[k*PARSE_ACT_LEN +: PARSE_ACT_LEN];
            idx   <= IDX_W'(1);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == IDX_END) state <= WAIT;
          else                idx   <= idx + 1'b1;
        end
        WAIT: begin
          // Absorbs the sub_parser's one-cycle latency for the last action.
          phv_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (phv_ready) begin
            phv_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Container collector, active in every state. Clearing on packet accept
  // takes priority: a result arriving in that cycle belongs to no packet.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phv_out <= '0;
    end else if (accept) begin
      phv_out <= '0;
    end else if (val_in_valid) begin
      case (val_in_type)
        2'b01:   phv_out[16*int'(val_in_seq[2:0]) +: 16]           <= val_in[15:0];
        2'b10:   phv_out[BASE_4B + 32*int'(val_in_seq[2:0]) +: 32] <= val_in[31:0];
        2'b11:   phv_out[BASE_6B + 48*int'(val_in_seq[2:0]) +: 48] <= val_in;
        default: ;  // type 00 carries no value
      endcase
    end
  end

`ifdef PARSE_ERR_CNT_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // Up to two error events per cycle: an enabled action with no type being
  // issued, and a result returned with no type.
  always_comb begin
    err_inc = {1'b0, issue_now && issue_act[0] && (issue_act[8:7] == 2'b00)} +
              {1'b0, val_in_valid && (val_in_type == 2'b00)};
    err_sum = {1'b0, err_cnt} + {15'b0, err_inc};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)        err_cnt <= '0;
    else if (err_sum[16]) err_cnt <= 16'hFFFF;
    else                 err_cnt <= err_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_parse_act_sched.sv
// -----------------------------------------------------------------------------
// tb_parse_act_sched
//
// Self-checking bench for parse_act_sched. A stub sub_parser answers each
// typed action one cycle later with header bits [off*8 +: 48], where the
// action layout used here is {seq[23:18], off[17:9], type[8:7], 6'b0, en[0]}.
// Expected PHVs and issue events are queued at packet acceptance; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
// Define PARSE_ERR_CNT_EN to also exercise the error counter.
// -----------------------------------------------------------------------------
module tb_parse_act_sched;

  localparam int HDR_W = 4096;
  localparam int ACT_W = 24;
  localparam int NA    = 10;
  localparam int CN    = 8;
  localparam int PHV_W = 768;

  logic                  clk = 1'b0;
  logic                  aresetn;
  logic                  s_valid;
  logic                  s_ready;
  logic [HDR_W-1:0]      s_pkts_hdr;
  logic [NA*ACT_W-1:0]   s_parse_acts;
  logic [HDR_W-1:0]      pkts_hdr;
  logic                  parse_act_valid;
  logic [ACT_W-1:0]      parse_act;
  logic                  val_in_valid;
  logic [47:0]           val_in;
  logic [1:0]            val_in_type;
  logic [5:0]            val_in_seq;
  logic                  phv_valid;
  logic                  phv_ready;
  logic [PHV_W-1:0]      phv_out;
`ifdef PARSE_ERR_CNT_EN
  logic [15:0]           err_cnt;
`endif

  always #5 clk = ~clk;

  parse_act_sched dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_pkts_hdr      (s_pkts_hdr),
    .s_parse_acts    (s_parse_acts),
    .pkts_hdr        (pkts_hdr),
    .parse_act_valid (parse_act_valid),
    .parse_act       (parse_act),
    .val_in_valid    (val_in_valid),
    .val_in          (val_in),
    .val_in_type     (val_in_type),
    .val_in_seq      (val_in_seq),
    .phv_valid       (phv_valid),
    .phv_ready       (phv_ready),
    .phv_out         (phv_out)
`ifdef PARSE_ERR_CNT_EN
    ,
    .err_cnt         (err_cnt)
`endif
  );

  // ---------------------------------------------------------------- counters
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [PHV_W-1:0] actual,
                       input logic [PHV_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------- stub sub_parser
  logic        stub_valid;
  logic [47:0] stub_val;
  logic [1:0]  stub_type;
  logic [5:0]  stub_seq;
  logic        inj_valid = 1'b0;
  logic [1:0]  inj_type  = 2'b00;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stub_valid <= 1'b0;
      stub_val   <= '0;
      stub_type  <= '0;
      stub_seq   <= '0;
    end else begin
      stub_valid <= parse_act_valid && (parse_act[8:7] != 2'b00);
      stub_type  <= parse_act[8:7];
      stub_seq   <= parse_act[23:18];
      stub_val   <= pkts_hdr[int'(parse_act[17:9])*8 +: 48];
    end
  end

  assign val_in_valid = inj_valid | stub_valid;
  assign val_in       = inj_valid ? 48'h0 : stub_val;
  assign val_in_type  = inj_valid ? inj_type : stub_type;
  assign val_in_seq   = inj_valid ? 6'h0 : stub_seq;

  // ------------------------------------------------------------- scoreboard
  typedef struct {
    logic [PHV_W-1:0] phv;
    int               t;
  } pkt_exp_t;

  typedef struct {
    int               cyc;
    logic [ACT_W-1:0] act;
  } iss_exp_t;

  pkt_exp_t phv_q[$];
  iss_exp_t iss_q[$];

  // Reference model: apply the enabled, typed actions in list order to three
  // banks of containers, then pack the banks into the PHV image.
  function automatic logic [PHV_W-1:0] model(input logic [HDR_W-1:0] hdr,
                                             input logic [NA*ACT_W-1:0] acts);
    logic [47:0]      cont [3][CN];
    logic [PHV_W-1:0] r;
    logic [PHV_W-1:0] v;
    logic [HDR_W-1:0] sh;
    logic [ACT_W-1:0] a;
    int               wid;
    int               base;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < CN; j++) cont[i][j] = '0;
    for (int k = 0; k < NA; k++) begin
      a = acts[k*ACT_W +: ACT_W];
      if (a[0] && a[8:7] != 2'b00) begin
        sh = hdr >> (int'(a[17:9]) * 8);
        cont[int'(a[8:7]) - 1][a[20:18]] = sh[47:0];
      end
    end
    r = '0;
    for (int i = 0; i < 3; i++) begin
      wid  = 16 * (i + 1);
      base = (i == 0) ? 0 : (i == 1) ? 16*CN : 48*CN;
      for (int j = 0; j < CN; j++) begin
        v = PHV_W'(cont[i][j]) & ((PHV_W'(1) << wid) - 1);
        r |= v << (base + wid*j);
      end
    end
    return r;
  endfunction

  function automatic logic [ACT_W-1:0] mk_act(input logic en, input logic [1:0] ty,
                                              input logic [8:0] off, input logic [5:0] seq);
    return {seq, off, ty, 6'b0, en};
  endfunction

  function automatic logic [HDR_W-1:0] rand_hdr();
    logic [HDR_W-1:0] h;
    for (int i = 0; i < HDR_W/32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic             prev_valid = 1'b0;
  logic             prev_hs    = 1'b0;
  logic [PHV_W-1:0] prev_phv;
  pkt_exp_t         mon_pe;
  iss_exp_t         mon_ie;

  always @(negedge clk) begin
    if (!aresetn) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (parse_act_valid) begin
        if (iss_q.size() == 0) fail_now("unexpected_issue");
        else begin
          mon_ie = iss_q.pop_front();
          check("issue_cycle", cyc, mon_ie.cyc);
          check("issue_act", parse_act, mon_ie.act);
        end
      end
      if (prev_hs) check("s_ready_after_hs", s_ready, 1);
      if (phv_valid) begin
        check("s_ready_low_in_out", s_ready, 0);
        if (!prev_valid || prev_hs) begin
          if (phv_q.size() == 0) fail_now("unexpected_phv");
          else check("phv_latency", cyc, phv_q[0].t + NA + 2);
        end else begin
          check("phv_stable", phv_out, prev_phv);
        end
        if (phv_ready && phv_q.size() != 0) begin
          mon_pe = phv_q.pop_front();
          check("phv_data", phv_out, mon_pe.phv);
        end
      end
      prev_hs    = phv_valid && phv_ready;
      prev_valid = phv_valid;
      prev_phv   = phv_out;
    end
  end

  // ------------------------------------------------------------------- sink
  int hold = 0;

  initial begin
    phv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        phv_ready = 1'b0;
        hold--;
      end else begin
        phv_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pkt(input logic [HDR_W-1:0] hdr, input logic [NA*ACT_W-1:0] acts,
                          input logic [PHV_W-1:0] exp_phv, output int t);
    int       budget;
    pkt_exp_t pe;
    iss_exp_t ie;
    budget       = 0;
    t            = -1;
    s_valid      = 1'b1;
    s_pkts_hdr   = hdr;
    s_parse_acts = acts;
    while (t < 0 && budget < 200) begin
      @(negedge clk);
      if (s_ready) begin
        t      = cyc;
        pe.phv = exp_phv;
        pe.t   = t;
        phv_q.push_back(pe);
        for (int k = 0; k < NA; k++) begin
          if (acts[k*ACT_W]) begin
            ie.cyc = t + 1 + k;
            ie.act = acts[k*ACT_W +: ACT_W];
            iss_q.push_back(ie);
          end
        end
      end
      budget++;
    end
    if (t < 0) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((phv_q.size() != 0 || iss_q.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", phv_q.size() + iss_q.size(), 0);
  endtask

  logic [HDR_W-1:0]    hdr;
  logic [NA*ACT_W-1:0] acts;
  logic [PHV_W-1:0]    exp_phv;
  int                  t;

  initial begin
    aresetn      = 1'b0;
    s_valid      = 1'b0;
    s_pkts_hdr   = '0;
    s_parse_acts = '0;
    repeat (3) @(posedge clk);
    #3 aresetn = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_phv_valid", phv_valid, 0);
    check("rst_act_valid", parse_act_valid, 0);
    check("rst_parse_act", parse_act, 0);
    check("rst_phv_out", phv_out, 0);
    check("rst_pkts_hdr_zero", |pkts_hdr, 0);
    @(posedge clk);
    #1;

    // Single 2B action: header bytes 4..5 into 2B container 3.
    hdr = '0;
    hdr[32 +: 16] = 16'hBEEF;
    acts = '0;
    acts[0 +: ACT_W] = mk_act(1'b1, 2'b01, 9'd4, 6'd3);
    exp_phv = '0;
    exp_phv[63:48] = 16'hBEEF;
    send_pkt(hdr, acts, exp_phv, t);
    wait_drain();

    // 4B into seq 0 from action 1, 6B into seq 7 from action 9.
    hdr = '0;
    hdr[80 +: 32]  = 32'hDEADBEEF;
    hdr[160 +: 48] = 48'h0123456789AB;
    acts = '0;
    acts[1*ACT_W +: ACT_W] = mk_act(1'b1, 2'b10, 9'd10, 6'd0);
    acts[9*ACT_W +: ACT_W] = mk_act(1'b1, 2'b11, 9'd20, 6'd7);
    exp_phv = '0;
    exp_phv[159:128] = 32'hDEADBEEF;
    exp_phv[767:720] = 48'h0123456789AB;
    send_pkt(hdr, acts, exp_phv, t);
    wait_drain();

    // Backpressure: phv_ready held low well past phv_valid rising.
    hdr = '0;
    hdr[32 +: 16] = 16'hBEEF;
    acts = '0;
    acts[0 +: ACT_W] = mk_act(1'b1, 2'b01, 9'd4, 6'd3);
    exp_phv = '0;
    exp_phv[63:48] = 16'hBEEF;
    send_pkt(hdr, acts, exp_phv, t);
    hold = 35;
    wait_drain();

    // Duplicate container index: the later action wins.
    hdr = '0;
    hdr[240 +: 16] = 16'h1111;
    hdr[320 +: 16] = 16'h2222;
    acts = '0;
    acts[2*ACT_W +: ACT_W] = mk_act(1'b1, 2'b01, 9'd30, 6'd1);
    acts[5*ACT_W +: ACT_W] = mk_act(1'b1, 2'b01, 9'd40, 6'd1);
    exp_phv = '0;
    exp_phv[31:16] = 16'h2222;
    send_pkt(hdr, acts, exp_phv, t);
    wait_drain();

    // All actions disabled (other fields non-zero): no issues, zero PHV.
    hdr = rand_hdr();
    acts = '0;
    for (int k = 0; k < NA; k++)
      acts[k*ACT_W +: ACT_W] = mk_act(1'b0, 2'b11, 9'(k*7), 6'(k));
    send_pkt(hdr, acts, '0, t);
    wait_drain();

    // Randomised packets, mostly back-to-back.
    for (int p = 0; p < 25; p++) begin
      hdr = rand_hdr();
      for (int k = 0; k < NA; k++)
        acts[k*ACT_W +: ACT_W] = mk_act(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                        9'($urandom_range(0, 500)), 6'($urandom_range(0, 63)));
      send_pkt(hdr, acts, model(hdr, acts), t);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    // Reset in the middle of issuing: packet abandoned, nothing emitted.
    hdr = rand_hdr();
    for (int k = 0; k < NA; k++)
      acts[k*ACT_W +: ACT_W] = mk_act(1'b1, 2'b01, 9'(k*3), 6'(k));
    send_pkt(hdr, acts, model(hdr, acts), t);
    while (cyc < t + 5) begin
      @(posedge clk);
      #2;
    end
    phv_q.delete();
    iss_q.delete();
    aresetn = 1'b0;
    #1;
    check("midrst_act_valid", parse_act_valid, 0);
    check("midrst_phv_valid", phv_valid, 0);
    check("midrst_phv_out", phv_out, 0);
    #4 aresetn = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_phv", phv_valid, 0);

`ifdef PARSE_ERR_CNT_EN
    aresetn = 1'b0;
    #3 aresetn = 1'b1;
    @(negedge clk);
    check("err_cnt_reset", err_cnt, 0);
    @(posedge clk);
    #1;
    hdr = rand_hdr();
    acts = '0;
    for (int k = 0; k < 3; k++)
      acts[k*ACT_W +: ACT_W] = mk_act(1'b1, 2'b00, 9'(k + 1), 6'(k));
    send_pkt(hdr, acts, '0, t);
    wait_drain();
    @(posedge clk);
    #1;
    inj_type  = 2'b00;
    inj_valid = 1'b1;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    @(negedge clk);
    check("err_cnt_four", err_cnt, 4);
    @(posedge clk);
    #1;
    inj_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    inj_valid = 1'b0;
    @(negedge clk);
    check("err_cnt_sat", err_cnt, 16'hFFFF);
    @(posedge clk);
    #1;
    send_pkt(hdr, acts, '0, t);
    wait_drain();
    check("err_cnt_sat_hold", err_cnt, 16'hFFFF);
`endif

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
